// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle processor control FSM: states, opcodes,
// datapath select codes, error codes and the bundled control-strobe struct.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that stall on the memory handshake and are guarded by the wait counter.
  function automatic logic is_mem_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational Moore decoder: maps the current state (plus mem_ready in FETCH)
// onto every datapath enable and mux select.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      S_DECODE:   ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM: sequences fetch/decode/execute, guards
// memory waits with a timeout, counts retired instructions and latches errors.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 halted,
  output logic [1:0]           err
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           err_q, err_d;
  logic [1:0]           err_new;
  logic                 timeout;
  logic                 retire;
  ctrl_t                ctrl;

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    err_new = ERR_NONE;
    timeout = is_mem_wait_state(state_q) && !mem_ready
              && (wait_q == WAIT_W'(MEM_WAIT_MAX - 1));

    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_HLT:       state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            err_new = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_ALU_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_new = ERR_ILLEGAL;
      end
    endcase

    // The stalled cycle's strobes stay asserted; only the successor changes.
    if (timeout) begin
      state_d = S_HALT;
      err_new = ERR_TIMEOUT;
    end

    if (is_mem_wait_state(state_q) && !mem_ready && (state_d == state_q))
      wait_d = wait_q + WAIT_W'(1);
    else
      wait_d = '0;

    retire = (state_d == S_FETCH) &&
             (state_q inside {S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB});
    cnt_d  = (retire && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    err_d  = (err_q == ERR_NONE) ? err_new : err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Write strobes are forced low while reset is held so no side effect escapes.
  assign pc_write      = ctrl.pc_write      & ~reset;
  assign pc_write_cond = ctrl.pc_write_cond & ~reset;
  assign mem_write     = ctrl.mem_write     & ~reset;
  assign ir_write      = ctrl.ir_write      & ~reset;
  assign reg_write     = ctrl.reg_write     & ~reset;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;

  assign state       = state_q;
  assign instr_count = cnt_q;
  assign halted      = (state_q == S_HALT);
  assign err         = err_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each scenario pushes the expected
// per-cycle outputs and compares them against the DUT half a cycle later.
module tb_mc_control_fsm;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  logic          halted;
  logic [1:0]    err;

  typedef struct {
    logic [22:0]   v;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt  = '0;

  mc_control_fsm #(.MEM_WAIT_MAX(15), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .instr_count   (instr_count),
    .halted        (halted),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference output table per state, independent of the DUT's encoding tables.
  function automatic logic [22:0] exp_vec(int s, logic r, logic [1:0] e);
    logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, h;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, h} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin mr = 1'b1; asb = 2'b01; pw = r; irw = r; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mr = 1'b1; io = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; io = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
      9:  begin pw = 1'b1; psrc = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; end
      11: rw = 1'b1;
      12: h = 1'b1;
      default: ;
    endcase
    return {4'(s), pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, h,
            (s == 12) ? e : 2'b00};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
            halted, err};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'h00;
    #1;
    sb.push_back('{exp_vec(0, 1'b0, 2'b00), '0});
    e = sb.pop_front();
    checks++;
    if (obs_vec() !== e.v || instr_count !== e.cnt) begin
      failures++;
      $display("FAIL reset_state: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
               obs_vec(), instr_count, e.v, e.cnt);
    end
    mem_ready = 1'b1;
    #1;
    // Write strobes must stay low under reset even with memory ready.
    sb.push_back('{exp_vec(0, 1'b0, 2'b00), '0});
    e = sb.pop_front();
    checks++;
    if (obs_vec() !== e.v || instr_count !== e.cnt) begin
      failures++;
      $display("FAIL reset_no_strobe: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
               obs_vec(), instr_count, e.v, e.cnt);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_rtype();
    int st[$];
    int rdy[$];
    exp_t e;
    st  = '{0, 1, 6, 7, 0};
    rdy = '{1, 1, 1, 1, 0};
    opcode = 6'b000000;
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = (rdy[i] != 0);
      if (i > 0 && st[i] == 0 && st[i-1] != 0) exp_cnt++;
      sb.push_back('{exp_vec(st[i], mem_ready, 2'b00), exp_cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_vec() !== e.v || instr_count !== e.cnt) begin
        failures++;
        $display("FAIL rtype cycle %0d: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
                 i, obs_vec(), instr_count, e.v, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    int st[$];
    int rdy[$];
    exp_t e;
    st  = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    rdy = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
    opcode = 6'b100011;
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = (rdy[i] != 0);
      if (i > 0 && st[i] == 0 && st[i-1] != 0) exp_cnt++;
      sb.push_back('{exp_vec(st[i], mem_ready, 2'b00), exp_cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_vec() !== e.v || instr_count !== e.cnt) begin
        failures++;
        $display("FAIL lw_wait cycle %0d: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
                 i, obs_vec(), instr_count, e.v, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int st[$];
    int ops[$];
    exp_t e;
    apply_reset();
    // BEQ, J, ADDI then two idle FETCH cycles: 12 cycles in all.
    st  = '{0, 1, 8, 0, 1, 9, 0, 1, 10, 11, 0, 0};
    ops = '{6'h04, 6'h04, 6'h04, 6'h02, 6'h02, 6'h02, 6'h08, 6'h08, 6'h08, 6'h08, 6'h00, 6'h00};
    for (int i = 0; i < st.size(); i++) begin
      opcode    = 6'(ops[i]);
      mem_ready = (i < 10);
      if (i > 0 && st[i] == 0 && st[i-1] != 0) exp_cnt++;
      sb.push_back('{exp_vec(st[i], mem_ready, 2'b00), exp_cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_vec() !== e.v || instr_count !== e.cnt) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
                 i, obs_vec(), instr_count, e.v, e.cnt);
      end
      @(negedge clk);
    end
    checks++;
    if (instr_count !== 32'd3) begin
      failures++;
      $display("FAIL back_to_back_count: got %0d, expected 3", instr_count);
    end
  endtask

  task automatic test_hlt();
    int st[$];
    int rdy[$];
    exp_t e;
    st  = '{0, 1};
    rdy = '{1, 1};
    repeat (20) begin
      st.push_back(12);
      rdy.push_back(int'($urandom_range(0, 1)));
    end
    opcode = 6'h3F;
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = (rdy[i] != 0);
      sb.push_back('{exp_vec(st[i], mem_ready, 2'b00), exp_cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_vec() !== e.v || instr_count !== e.cnt) begin
        failures++;
        $display("FAIL hlt cycle %0d: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
                 i, obs_vec(), instr_count, e.v, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    int st[$];
    exp_t e;
    apply_reset();
    st = '{0, 1};
    repeat (20) st.push_back(12);
    opcode = 6'h05;
    for (int i = 0; i < st.size(); i++) begin
      // Starving memory while halted must not overwrite the first error.
      mem_ready = (i < 2);
      sb.push_back('{exp_vec(st[i], mem_ready, 2'b01), exp_cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_vec() !== e.v || instr_count !== e.cnt) begin
        failures++;
        $display("FAIL illegal cycle %0d: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
                 i, obs_vec(), instr_count, e.v, e.cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int st[$];
    exp_t e;
    apply_reset();
    st = '{0, 1, 6, 7};
    repeat (15) st.push_back(0);
    repeat (3)  st.push_back(12);
    opcode = 6'b000000;
    for (int i = 0; i < st.size(); i++) begin
      mem_ready = (i < 4);
      if (i > 0 && st[i] == 0 && st[i-1] != 0) exp_cnt++;
      sb.push_back('{exp_vec(st[i], mem_ready, 2'b10), exp_cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_vec() !== e.v || instr_count !== e.cnt) begin
        failures++;
        $display("FAIL timeout cycle %0d: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
                 i, obs_vec(), instr_count, e.v, e.cnt);
      end
      @(negedge clk);
    end
    // Asynchronous reset from HALT must take effect without a clock edge.
    reset = 1'b1;
    exp_cnt = '0;
    sb.push_back('{exp_vec(0, 1'b0, 2'b00), exp_cnt});
    #1;
    e = sb.pop_front();
    checks++;
    if (obs_vec() !== e.v || instr_count !== e.cnt) begin
      failures++;
      $display("FAIL reset_mid_halt: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
               obs_vec(), instr_count, e.v, e.cnt);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_hlt();
    test_illegal();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
